// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and default sizes for the SRAM port arbiter.
// Holds the controller state type, the grant-owner type and the
// AW/DW/DEPTH defaults used by the interface and the top.
package sram_port_arbiter_pkg;

    localparam int AW_DEFAULT    = 8;
    localparam int DW_DEFAULT    = 7;
    localparam int DEPTH_DEFAULT = 256;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_W,
        GNT_R
    } gnt_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the requesters/SRAM and the SRAM port arbiter.
//   write request : w_valid, w_ready, w_addr, w_data
//   read request  : r_valid, r_ready, r_addr
//   read response : r_resp_valid, r_resp_data
//   SRAM port     : mem_en, mem_wmode, mem_addr, mem_wdata, mem_rdata
// master = requesters plus SRAM macro side, slave = arbiter side.
interface sram_port_arbiter_if
    import sram_port_arbiter_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
);
    logic          w_valid;
    logic          w_ready;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          r_valid;
    logic          r_ready;
    logic [AW-1:0] r_addr;
    logic          r_resp_valid;
    logic [DW-1:0] r_resp_data;
    logic          mem_en;
    logic          mem_wmode;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        output w_valid, w_addr, w_data, r_valid, r_addr, mem_rdata,
        input  w_ready, r_ready, r_resp_valid, r_resp_data,
        input  mem_en, mem_wmode, mem_addr, mem_wdata
    );

    modport slave (
        input  w_valid, w_addr, w_data, r_valid, r_addr, mem_rdata,
        output w_ready, r_ready, r_resp_valid, r_resp_data,
        output mem_en, mem_wmode, mem_addr, mem_wdata
    );

endinterface

// File: rtl/sram_port_arbiter_rr_arb2.sv
// sram_rr_arb2: two-input round-robin arbiter (write vs read).
// Ports: clock, reset_n (async, active low), enable (arbitration allowed),
//        w_valid/r_valid (requests), w_ready/r_ready (grants, combinational),
//        gnt (grant owner this cycle).
// A lone requester is granted at once; with both valid the one not granted
// most recently wins. The pointer moves only on a grant and favours write
// after reset.
module sram_rr_arb2
    import sram_port_arbiter_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    input  logic w_valid,
    input  logic r_valid,
    output logic w_ready,
    output logic r_ready,
    output gnt_t gnt
);

    // 1: read wins a tie, 0: write wins a tie
    logic prio_r;

    always_comb begin
        gnt = GNT_NONE;
        if (enable) begin
            if (w_valid && (!r_valid || !prio_r)) begin
                gnt = GNT_W;
            end else if (r_valid) begin
                gnt = GNT_R;
            end
        end
    end

    assign w_ready = (gnt == GNT_W);
    assign r_ready = (gnt == GNT_R);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prio_r <= 1'b0;
        end else if (gnt == GNT_W) begin
            prio_r <= 1'b1;
        end else if (gnt == GNT_R) begin
            prio_r <= 1'b0;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port SRAM between a write and a
// read requester, at most one SRAM access per cycle.
// Ports: clock, reset_n (async, active low), bus (slave modport of
//        sram_port_arbiter_if: request, response and SRAM signals),
//        init_done (clear sweep finished, requests accepted).
// Build option SRAM_PORT_ARBITER_INIT_CLEAR_EN: when defined, the SRAM is
// cleared to zero by a sweep over every address after reset before any
// request is accepted; otherwise requests are accepted straight away.
// Read data passes through from mem_rdata; r_resp_valid marks the cycle
// after a read grant.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int AW    = AW_DEFAULT,
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
)(
    input  logic               clock,
    input  logic               reset_n,
    sram_port_arbiter_if.slave bus,
    output logic               init_done
);

    if (DEPTH != (1 << AW)) begin : g_depth_check
        $error("sram_port_arbiter: DEPTH must equal 2**AW");
    end

    gnt_t gnt;
    logic run;

`ifdef SRAM_PORT_ARBITER_INIT_CLEAR_EN
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] init_cnt;
    logic          sweep;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    // sweep/run are qualified by reset_n so the SRAM port stays idle
    // while reset is held even though the state register sits in INIT.
    always_comb begin
        state_next = state;
        sweep      = 1'b0;
        run        = 1'b0;
        case (state)
            INIT: begin
                sweep = reset_n;
                if (init_cnt == LAST_ADDR) begin
                    state_next = RUN;
                end
            end
            RUN: run = reset_n;
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            init_cnt <= '0;
        end else if (state == INIT) begin
            init_cnt <= init_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            init_done <= 1'b0;
        end else begin
            init_done <= (state_next == RUN);
        end
    end
`else
    assign run       = reset_n;
    assign init_done = 1'b1;
`endif

    sram_rr_arb2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (run),
        .w_valid (bus.w_valid),
        .r_valid (bus.r_valid),
        .w_ready (bus.w_ready),
        .r_ready (bus.r_ready),
        .gnt     (gnt)
    );

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_wmode = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (gnt)
            GNT_W: begin
                bus.mem_en    = 1'b1;
                bus.mem_wmode = 1'b1;
                bus.mem_addr  = bus.w_addr;
                bus.mem_wdata = bus.w_data;
            end
            GNT_R: begin
                bus.mem_en    = 1'b1;
                bus.mem_addr  = bus.r_addr;
            end
            default: ;
        endcase
`ifdef SRAM_PORT_ARBITER_INIT_CLEAR_EN
        // sweep and grants are mutually exclusive (no grant outside RUN)
        if (sweep) begin
            bus.mem_en    = 1'b1;
            bus.mem_wmode = 1'b1;
            bus.mem_addr  = init_cnt;
            bus.mem_wdata = '0;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.r_resp_valid <= 1'b0;
        end else begin
            bus.r_resp_valid <= (gnt == GNT_R);
        end
    end

    assign bus.r_resp_data = bus.mem_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: SRAM behavioural model, a
// reference model of the arbitration rules and memory contents, directed
// scenarios followed by randomized request traffic.
module tb_sram_port_arbiter;

    localparam int AW    = 8;
    localparam int DW    = 7;
    localparam int DEPTH = 256;

    logic clock;
    logic reset_n;
    logic init_done;

    int checks = 0;
    int errors = 0;

    sram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    sram_port_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .init_done (init_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [DW-1:0] fill_pattern(input int unsigned a);
        return DW'(a * 37 + 5);
    endfunction

    // Single-port synchronous SRAM: read data valid the cycle after enable.
    logic [DW-1:0] sram [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) sram[i] = fill_pattern(i);
        bus.mem_rdata = '0;
        forever begin
            @(posedge clock);
            if (bus.mem_en) begin
                if (bus.mem_wmode) sram[bus.mem_addr] <= bus.mem_wdata;
                else               bus.mem_rdata <= sram[bus.mem_addr];
            end
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    bit            last_was_w;   // owner of the most recent grant (1 = write)
    bit            resp_pend;
    logic [DW-1:0] resp_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        last_was_w = 1'b0;   // after reset write is favoured
        resp_pend  = 1'b0;
    endtask

    // One request cycle: drive at negedge, check combinational outputs and
    // the response from the previous cycle, then update the model at posedge.
    task automatic step(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic rv, input logic [AW-1:0] ra);
        logic exp_w, exp_r;
        @(negedge clock);
        bus.w_valid = wv; bus.w_addr = wa; bus.w_data = wd;
        bus.r_valid = rv; bus.r_addr = ra;
        #1;
        exp_w = wv && (!rv || !last_was_w);
        exp_r = rv && !exp_w;
        chk("w_ready", bus.w_ready, exp_w);
        chk("r_ready", bus.r_ready, exp_r);
        chk("mem_en", bus.mem_en, exp_w || exp_r);
        chk("mem_wmode", bus.mem_wmode, exp_w);
        chk("mem_addr", bus.mem_addr, exp_w ? wa : (exp_r ? ra : '0));
        chk("mem_wdata", bus.mem_wdata, exp_w ? wd : '0);
        chk("r_resp_valid", bus.r_resp_valid, resp_pend);
        if (resp_pend) chk("r_resp_data", bus.r_resp_data, resp_exp);
        chk("init_done_run", init_done, 1'b1);
        @(posedge clock);
        resp_pend = exp_r;
        if (exp_w) begin
            ref_mem[wa] = wd;
            last_was_w  = 1'b1;
        end
        if (exp_r) begin
            resp_exp   = ref_mem[ra];
            last_was_w = 1'b0;
        end
    endtask

    // Clear sweep: n cycles starting at the current negedge, requests held
    // high to show nothing is accepted meanwhile.
    task automatic sweep_check(input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clock);
            bus.w_valid = 1'b1; bus.r_valid = 1'b1;
            #1;
            chk("sweep_en", bus.mem_en, 1'b1);
            chk("sweep_wmode", bus.mem_wmode, 1'b1);
            chk("sweep_addr", bus.mem_addr, i);
            chk("sweep_wdata", bus.mem_wdata, 0);
            chk("sweep_w_ready", bus.w_ready, 1'b0);
            chk("sweep_r_ready", bus.r_ready, 1'b0);
            chk("sweep_init_done", init_done, 1'b0);
        end
    endtask

    // Release reset at a negedge and bring the block to RUN.
    task automatic release_reset();
        reset_n = 1'b1;
        model_reset();
`ifdef SRAM_PORT_ARBITER_INIT_CLEAR_EN
        sweep_check(DEPTH);
        @(negedge clock);
        bus.w_valid = 1'b0; bus.r_valid = 1'b0;
        #1;
        chk("init_done_rise", init_done, 1'b1);
        chk("post_sweep_en", bus.mem_en, 1'b0);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`else
        bus.w_valid = 1'b0; bus.r_valid = 1'b0;
        #1;
        chk("init_done_first", init_done, 1'b1);
`endif
    endtask

    task automatic check_in_reset();
        #1;
        chk("rst_mem_en", bus.mem_en, 1'b0);
        chk("rst_w_ready", bus.w_ready, 1'b0);
        chk("rst_r_ready", bus.r_ready, 1'b0);
        chk("rst_r_resp_valid", bus.r_resp_valid, 1'b0);
`ifdef SRAM_PORT_ARBITER_INIT_CLEAR_EN
        chk("rst_init_done", init_done, 1'b0);
`else
        chk("rst_init_done", init_done, 1'b1);
`endif
    endtask

    initial begin
        reset_n = 1'b0;
        bus.w_valid = 1'b1; bus.w_addr = '0; bus.w_data = '0;
        bus.r_valid = 1'b1; bus.r_addr = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = fill_pattern(i);
        model_reset();
        resp_exp = '0;

        repeat (2) @(negedge clock);
        check_in_reset();
        @(negedge clock);
        release_reset();

        // Write then read-after-write on the same address
        step(1'b1, 8'h10, 7'h55, 1'b0, 8'h00);
        step(1'b0, 8'h00, 7'h00, 1'b1, 8'h10);
        step(1'b0, 8'h00, 7'h00, 1'b0, 8'h00);
        chk("raw_model", {25'd0, ref_mem[8'h10]}, 32'h55);

        // Both valid for six cycles after a read grant: W,R,W,R,W,R
        for (int i = 0; i < 6; i++)
            step(1'b1, 8'(8'h20 + i), 7'(7'h30 + i), 1'b1, 8'(8'h20 + i));
        step(1'b0, 8'h00, 7'h00, 1'b0, 8'h00);

        // Unwritten address
        step(1'b0, 8'h00, 7'h00, 1'b1, 8'hFF);
        step(1'b0, 8'h00, 7'h00, 1'b0, 8'h00);

        // Write 0x7F to 0x01 and read it back
        step(1'b1, 8'h01, 7'h7F, 1'b0, 8'h00);
        step(1'b0, 8'h00, 7'h00, 1'b1, 8'h01);
        step(1'b0, 8'h00, 7'h00, 1'b0, 8'h00);

        // Randomized traffic over a small address window
        for (int n = 0; n < 300; n++)
            step(logic'($urandom_range(0, 99) < 60), 8'($urandom_range(0, 15)), 7'($urandom),
                 logic'($urandom_range(0, 99) < 60), 8'($urandom_range(0, 15)));
        step(1'b0, 8'h00, 7'h00, 1'b0, 8'h00);

        // Reset while a read is granted: no response may follow
        @(negedge clock);
        bus.w_valid = 1'b0; bus.r_valid = 1'b1; bus.r_addr = 8'h05;
        #1;
        chk("pre_abort_r_ready", bus.r_ready, 1'b1);
        reset_n = 1'b0;
        check_in_reset();
        @(posedge clock);
        #1;
        chk("abort_no_resp", bus.r_resp_valid, 1'b0);
        @(negedge clock);
        release_reset();
        step(1'b0, 8'h00, 7'h00, 1'b0, 8'h00);

`ifdef SRAM_PORT_ARBITER_INIT_CLEAR_EN
        // Reset mid-sweep at address 100: sweep restarts from 0
        @(negedge clock);
        reset_n = 1'b0;
        check_in_reset();
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        sweep_check(101);
        reset_n = 1'b0;
        check_in_reset();
        @(negedge clock);
        release_reset();
        step(1'b0, 8'h00, 7'h00, 1'b1, 8'h10);
        step(1'b0, 8'h00, 7'h00, 1'b0, 8'h00);
`endif

        // Short random burst after the second reset (pointer favours write)
        for (int n = 0; n < 40; n++)
            step(logic'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 7'($urandom),
                 logic'($urandom_range(0, 1)), 8'($urandom_range(0, 7)));
        step(1'b0, 8'h00, 7'h00, 1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
